// File: rtl/bus_arbiter.sv
// bus_arbiter: grants a shared serial bus to one of N_MST masters at a time.
// It parks one split transaction and resumes it with priority once the slave
// is ready, and it revokes a grant that is held past a timeout.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest requesting index wins (fixed priority).
module bus_arbiter #(
  parameter int N_MST       = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     in_clk,
  input  logic                     reset_n,
  input  logic [N_MST-1:0]         breq,
  input  logic                     split_en,
  output logic [N_MST-1:0]         bgrant,
  output logic [$clog2(N_MST)-1:0] gnt_idx,
  output logic                     bus_busy,
  output logic                     split_active,
  output logic                     timeout_err
);

  localparam int IDX_W = $clog2(N_MST);
  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_MST-1:0]   bgrant_q, bgrant_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic               split_active_q, split_active_d;
  logic [IDX_W-1:0]   split_owner_q, split_owner_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

  logic               split_release;
  logic [N_MST-1:0]   eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Index following i, wrapping at N_MST (works for non-power-of-two counts).
  function automatic logic [IDX_W-1:0] idx_after(input logic [IDX_W-1:0] i);
    return (int'(i) == N_MST - 1) ? '0 : i + 1'b1;
  endfunction
`endif

  // Requesters allowed to win normal arbitration: the parked split master is
  // masked out unless its slot is being abandoned this cycle.
  always_comb begin
    split_release = split_active_q && !split_en && !breq[split_owner_q];
    eligible      = breq;
    if (split_active_q && !split_release) begin
      eligible[split_owner_q] = 1'b0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin winner: scan upward from the pointer, first eligible wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_MST; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_MST) begin
        cand = cand - N_MST;
      end
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end
`else
  // Fixed-priority winner: scan downward so the lowest index is kept last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(k);
      end
    end
  end
`endif

  // Next-state and registered-output logic for the IDLE/OWNED machine.
  always_comb begin
    state_d        = state_q;
    bgrant_d       = bgrant_q;
    gnt_idx_d      = gnt_idx_q;
    split_active_d = split_active_q;
    split_owner_d  = split_owner_q;
    timeout_err_d  = 1'b0;
    hold_cnt_d     = hold_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_d       = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        bgrant_d   = '0;
        hold_cnt_d = '0;
        if (split_active_q && !split_en && breq[split_owner_q]) begin
          // Ready split slave: its master resumes ahead of everyone else.
          bgrant_d       = N_MST'(1) << split_owner_q;
          gnt_idx_d      = split_owner_q;
          split_active_d = 1'b0;
          state_d        = ST_OWNED;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_d       = idx_after(split_owner_q);
`endif
        end else begin
          if (split_release) begin
            split_active_d = 1'b0;
          end
          if (win_found) begin
            bgrant_d  = N_MST'(1) << win_idx;
            gnt_idx_d = win_idx;
            state_d   = ST_OWNED;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_d  = idx_after(win_idx);
`endif
          end
        end
      end
      ST_OWNED: begin
        if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
        if (split_en && !split_active_q) begin
          // Park the current owner; the single split slot is now taken.
          split_owner_d  = gnt_idx_q;
          split_active_d = 1'b1;
          bgrant_d       = '0;
          state_d        = ST_IDLE;
        end else if (!breq[gnt_idx_q]) begin
          bgrant_d = '0;
          state_d  = ST_IDLE;
        end else if ((TIMEOUT_CYC != 0) && (hold_cnt_q == CNT_LAST)) begin
          bgrant_d      = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        bgrant_d = '0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bgrant_q       <= '0;
      gnt_idx_q      <= '0;
      split_active_q <= 1'b0;
      split_owner_q  <= '0;
      timeout_err_q  <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      bgrant_q       <= bgrant_d;
      gnt_idx_q      <= gnt_idx_d;
      split_active_q <= split_active_d;
      split_owner_q  <= split_owner_d;
      timeout_err_q  <= timeout_err_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin start pointer, advanced past every granted index.
  always_ff @(posedge in_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign bgrant       = bgrant_q;
  assign gnt_idx      = gnt_idx_q;
  assign bus_busy     = (state_q == ST_OWNED);
  assign split_active = split_active_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter with hand-computed expectations.
// Instance dut uses TIMEOUT_CYC=8; dut_nt uses TIMEOUT_CYC=0 (no timeout).
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] breq = 2'b00;
  logic       split_en = 1'b0;
  logic [1:0] bgrant;
  logic [0:0] gnt_idx;
  logic       bus_busy, split_active, timeout_err;

  logic [1:0] breq_nt = 2'b00;
  logic       split_en_nt = 1'b0;
  logic [1:0] bgrant_nt;
  logic [0:0] gnt_idx_nt;
  logic       bus_busy_nt, split_active_nt, timeout_err_nt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MST(2), .TIMEOUT_CYC(8)) dut (
    .in_clk(clk), .reset_n(reset_n), .breq(breq), .split_en(split_en),
    .bgrant(bgrant), .gnt_idx(gnt_idx), .bus_busy(bus_busy),
    .split_active(split_active), .timeout_err(timeout_err)
  );

  bus_arbiter #(.N_MST(2), .TIMEOUT_CYC(0)) dut_nt (
    .in_clk(clk), .reset_n(reset_n), .breq(breq_nt), .split_en(split_en_nt),
    .bgrant(bgrant_nt), .gnt_idx(gnt_idx_nt), .bus_busy(bus_busy_nt),
    .split_active(split_active_nt), .timeout_err(timeout_err_nt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] first_g;
  logic [1:0] other_g;
  bit         held_ok;

  initial begin
    // Reset
    #2 reset_n = 1'b0;
    step();
    step();
    check_eq("rst_bgrant", bgrant, 2'b00);
    check_eq("rst_gnt_idx", gnt_idx, 1'b0);
    check_eq("rst_busy", bus_busy, 1'b0);
    check_eq("rst_split", split_active, 1'b0);
    check_eq("rst_tmo", timeout_err, 1'b0);
    check_eq("rst_nt_bgrant", bgrant_nt, 2'b00);
    reset_n = 1'b1;
    step();
    $display("txn reset: bgrant=%b busy=%b", bgrant, bus_busy);

    // 1: single request, one-cycle grant, release next cycle
    breq = 2'b01;
    step();
    check_eq("t1_grant", bgrant, 2'b01);
    check_eq("t1_busy", bus_busy, 1'b1);
    check_eq("t1_idx", gnt_idx, 1'b0);
    breq = 2'b00;
    step();
    check_eq("t1_release", bgrant, 2'b00);
    check_eq("t1_idle", bus_busy, 1'b0);
    check_eq("t1_idx_hold", gnt_idx, 1'b0);
    $display("txn single: M0 granted and released");

    // 2a: both request; winner releases, one idle cycle, other granted
    first_g = RR_MODE ? 2'b10 : 2'b01;
    other_g = ~first_g;
    breq = 2'b11;
    step();
    check_eq("t2_first", bgrant, first_g);
    breq = other_g;
    step();
    check_eq("t2_turnaround", bgrant, 2'b00);
    step();
    check_eq("t2_second", bgrant, other_g);
    breq = 2'b00;
    step();
    check_eq("t2_idle", bgrant, 2'b00);
    check_eq("t2_idx_hold", gnt_idx, {1'b0, other_g[1]});
    $display("txn contend: first=%b second=%b", first_g, other_g);

    // 2b: four consecutive contended requests
    for (int k = 0; k < 4; k++) begin
      breq = 2'b11;
      step();
      check_eq($sformatf("t2_seq%0d", k), bgrant,
               RR_MODE ? ((k % 2 == 0) ? 2'b10 : 2'b01) : 2'b01);
      $display("txn seq%0d: bgrant=%b", k, bgrant);
      breq = 2'b00;
      step();
    end

    // 3: split capture, M1 served, split resume with priority
    breq = 2'b01;
    step();
    check_eq("t3_m0", bgrant, 2'b01);
    split_en = 1'b1;
    step();
    check_eq("t3_cap_grant", bgrant, 2'b00);
    check_eq("t3_cap_split", split_active, 1'b1);
    breq = 2'b11;
    step();
    check_eq("t3_m1", bgrant, 2'b10);
    step();
    check_eq("t3_no_2nd_split", bgrant, 2'b10);
    split_en = 1'b0;
    step();
    check_eq("t3_no_preempt", bgrant, 2'b10);
    check_eq("t3_still_parked", split_active, 1'b1);
    breq = 2'b01;
    step();
    check_eq("t3_m1_rel", bgrant, 2'b00);
    step();
    check_eq("t3_resume", bgrant, 2'b01);
    check_eq("t3_split_clr", split_active, 1'b0);
    breq = 2'b00;
    step();
    $display("txn split: M0 parked, M1 served, M0 resumed");

    // breq drop with split_en in the same cycle: capture wins
    breq = 2'b01;
    step();
    breq = 2'b00;
    split_en = 1'b1;
    step();
    check_eq("t3b_grant", bgrant, 2'b00);
    check_eq("t3b_split", split_active, 1'b1);
    // 5: slave ready but owner no longer requests -> slot abandoned, M1 granted
    split_en = 1'b0;
    breq = 2'b10;
    step();
    check_eq("t5_split_clr", split_active, 1'b0);
    check_eq("t5_m1", bgrant, 2'b10);
    breq = 2'b00;
    step();
    $display("txn abandon: split slot released, M1 granted");

    // 4: timeout after 8 owned cycles, one-cycle error pulse
    breq = 2'b10;
    step();
    check_eq("t4_grant", bgrant, 2'b10);
    for (int k = 1; k < 8; k++) begin
      step();
      check_eq($sformatf("t4_hold%0d", k), {bgrant, timeout_err}, {2'b10, 1'b0});
    end
    step();
    check_eq("t4_revoked", bgrant, 2'b00);
    check_eq("t4_err", timeout_err, 1'b1);
    step();
    check_eq("t4_err_pulse", timeout_err, 1'b0);
    check_eq("t4_regrant", bgrant, 2'b10);
    breq = 2'b00;
    step();
    step();
    $display("txn timeout: revoked after 8 cycles");

    // 4b: timeout disabled, grant held 2000 cycles
    breq_nt = 2'b01;
    step();
    held_ok = (bgrant_nt === 2'b01);
    for (int k = 0; k < 2000; k++) begin
      step();
      if (bgrant_nt !== 2'b01 || timeout_err_nt !== 1'b0) held_ok = 1'b0;
    end
    check_eq("t4_no_timeout", held_ok, 1'b1);
    breq_nt = 2'b00;
    step();
    check_eq("t4_nt_release", bgrant_nt, 2'b00);
    $display("txn no-timeout: grant held 2000 cycles");

    // 6: async reset mid-ownership with a parked split
    breq = 2'b01;
    step();
    split_en = 1'b1;
    step();
    breq = 2'b11;
    step();
    check_eq("t6_m1", bgrant, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_async_grant", bgrant, 2'b00);
    check_eq("t6_async_busy", bus_busy, 1'b0);
    check_eq("t6_async_split", split_active, 1'b0);
    check_eq("t6_async_idx", gnt_idx, 1'b0);
    split_en = 1'b0;
    step();
    #2 reset_n = 1'b1;
    step();
    check_eq("t6_after_rst", bgrant, 2'b01);
    breq = 2'b00;
    step();
    $display("txn reset-mid: outputs cleared, arbitration resumed");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
